// File: rtl/microcontroller_v2_pkg.sv
// rtl/microcontroller_v2_pkg.sv - shared opcode, FSM state, ALU op and flag-index definitions
package microcontroller_v2_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LD    = 4'h2,
        OP_ST    = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_ADDI  = 4'h9,
        OP_JMP   = 4'hA,
        OP_JZ    = 4'hB,
        OP_JC    = 4'hC,
        OP_RETI  = 4'hD,
        OP_SETIE = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IRQ   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    // Bit positions inside the 2-bit {Z,C} flag vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;

endpackage

// File: rtl/microcontroller_v2_alu.sv
// rtl/microcontroller_v2_alu.sv - mcu_alu: accumulator ALU with carry/borrow and zero outputs
module mcu_alu
    import microcontroller_v2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // The extra top bit is carry-out for ADD and borrow (a < b) for SUB.
    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = {1'b0, b};
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        zero   = (wide[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/microcontroller_v2.sv
// rtl/microcontroller_v2.sv - two-cycle accumulator MCU with memory-mapped output ports
// Optional interrupt support (IE, RET_PC, IRQ state, RETI/SETIE) is built only with MCU_IRQ_EN.
module microcontroller_v2
    import microcontroller_v2_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                NUM_PORTS = 4,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(8'hF0)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        irq,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [ADDR_W+3:0]           rom_data,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    output logic                        irq_ack
);

    localparam int RAM_DEPTH = 1 << ADDR_W;
    localparam int PORT_BASE = RAM_DEPTH - NUM_PORTS;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W+3:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [1:0]        flags_q, flags_d;
    logic [DATA_W-1:0] port_q [NUM_PORTS];
    logic [DATA_W-1:0] port_d [NUM_PORTS];
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic              ram_we;

    opcode_e           op;
    logic [ADDR_W-1:0] k;
    logic [DATA_W-1:0] k_data, rd_data, alu_b, alu_res;
    logic              is_port, alu_carry, alu_zero;
    alu_op_e           alu_op;

`ifdef MCU_IRQ_EN
    logic              ie_q, ie_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic [1:0]        saved_flags_q, saved_flags_d;
    logic              irq_ack_q, irq_ack_d;
    assign irq_ack = irq_ack_q;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_ack    = 1'b0;
`endif

    assign op       = opcode_e'(ir_q[3:0]);
    assign k        = ir_q[ADDR_W+3:4];
    assign k_data   = DATA_W'(k);
    assign rom_addr = pc_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
        assign port_out[g*DATA_W +: DATA_W] = port_q[g];
    end

    // The top NUM_PORTS data addresses alias the port registers.
    always_comb begin
        rd_data = ram[k];
        is_port = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (k == ADDR_W'(PORT_BASE + p)) begin
                rd_data = port_q[p];
                is_port = 1'b1;
            end
        end
    end

    always_comb begin
        alu_b  = rd_data;
        alu_op = ALU_PASS;
        case (op)
            OP_LDI:  alu_b = k_data;
            OP_ADDI: begin
                alu_b  = k_data;
                alu_op = ALU_ADD;
            end
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            default: alu_op = ALU_PASS;
        endcase
    end

    mcu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (acc_q),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        port_d  = port_q;
        ram_we  = 1'b0;
`ifdef MCU_IRQ_EN
        ie_d          = ie_q;
        ret_pc_d      = ret_pc_q;
        saved_flags_d = saved_flags_q;
        irq_ack_d     = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LDI, OP_LD, OP_AND, OP_OR, OP_XOR: begin
                        acc_d           = alu_res;
                        flags_d[FLAG_Z] = alu_zero;
                    end
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        acc_d           = alu_res;
                        flags_d[FLAG_Z] = alu_zero;
                        flags_d[FLAG_C] = alu_carry;
                    end
                    OP_ST: begin
                        ram_we = !is_port;
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (k == ADDR_W'(PORT_BASE + p)) port_d[p] = acc_q;
                        end
                    end
                    OP_JMP:  pc_d = k;
                    OP_JZ:   if (flags_q[FLAG_Z]) pc_d = k;
                    OP_JC:   if (flags_q[FLAG_C]) pc_d = k;
                    OP_HALT: state_d = ST_EXEC;
`ifdef MCU_IRQ_EN
                    OP_RETI: begin
                        pc_d    = ret_pc_q;
                        flags_d = saved_flags_q;
                        ie_d    = 1'b1;
                    end
                    OP_SETIE: ie_d = k[0];
`endif
                    default: ;
                endcase
`ifdef MCU_IRQ_EN
                // Interrupt is taken after the instruction, so pc_d already holds the resume point.
                if (ie_q && irq) begin
                    state_d   = ST_IRQ;
                    irq_ack_d = 1'b1;
                end
`endif
            end
`ifdef MCU_IRQ_EN
            ST_IRQ: begin
                ret_pc_d      = pc_q;
                saved_flags_d = flags_q;
                ie_d          = 1'b0;
                pc_d          = IRQ_VEC;
                state_d       = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) port_q[p] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            port_q  <= port_d;
        end
    end

`ifdef MCU_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q          <= 1'b0;
            ret_pc_q      <= '0;
            saved_flags_q <= '0;
            irq_ack_q     <= 1'b0;
        end else begin
            ie_q          <= ie_d;
            ret_pc_q      <= ret_pc_d;
            saved_flags_q <= saved_flags_d;
            irq_ack_q     <= irq_ack_d;
        end
    end
`endif

    // RAM is deliberately not reset; a reset cycle only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) ram[k] <= acc_q;
    end

endmodule

// File: tb/tb_microcontroller_v2.sv
// tb/tb_microcontroller_v2.sv - scoreboard bench for microcontroller_v2 (port writes, PC flow, irq_ack)
module tb_microcontroller_v2;
    import microcontroller_v2_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              irq = 1'b0;
    logic [AW-1:0]     rom_addr;
    logic [AW+3:0]     rom_data;
    logic [NP*DW-1:0]  port_out;
    logic              irq_ack;
    logic [AW+3:0]     rom [256];

    assign rom_data = rom[rom_addr];

    microcontroller_v2 #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_PORTS (NP),
        .IRQ_VEC   (8'hF0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .port_out (port_out),
        .irq_ack  (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] port;
        logic [7:0] val;
    } wr_t;

    int               checks    = 0;
    int               failures  = 0;
    int               ack_count = 0;
    wr_t              sb_q[$];
    wr_t              exp_wr;
    logic [NP*DW-1:0] prev_ports = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every observed port change must match the oldest pending expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (irq_ack) ack_count++;
            for (int p = 0; p < NP; p++) begin
                if (port_out[p*DW +: DW] !== prev_ports[p*DW +: DW]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", sb_q.size(), 1);
                    end else begin
                        exp_wr = sb_q.pop_front();
                        check_eq("sb_port_write", {p[2:0], port_out[p*DW +: DW]}, exp_wr);
                    end
                end
            end
        end
        prev_ports = port_out;
    end

    function automatic logic [11:0] ins(input opcode_e op, input logic [7:0] k);
        return {k, 4'(op)};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 8'h00);
        sb_q.delete();
    endtask

    task automatic expect_wr(input int port, input logic [7:0] val);
        sb_q.push_back(wr_t'{port: 3'(port), val: val});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit got_ack;

    initial begin
        // Store to port 0, then HALT with frozen PC.
        clear_rom();
        rom[0] = ins(OP_LDI, 8'h05);
        rom[1] = ins(OP_ST, 8'hFC);
        rom[2] = ins(OP_HALT, 8'h00);
        expect_wr(0, 8'h05);
        do_reset();
        check_eq("rst_rom_addr", rom_addr, 0);
        check_eq("rst_port_out", port_out, 0);
        check_eq("rst_irq_ack", irq_ack, 0);
        run_cycles(3);
        check_eq("t1_port0_before_st", port_out[7:0], 8'h00);
        run_cycles(1);
        check_eq("t1_port0_after4", port_out[7:0], 8'h05);
        run_cycles(2);
        check_eq("t1_halt_pc", rom_addr, 8'h03);
        run_cycles(5);
        check_eq("t1_halt_pc_frozen", rom_addr, 8'h03);
        check_eq("t1_sb_drained", sb_q.size(), 0);

        // 0xFF + 1 -> 0, Z=1, C=1; JC then JZ taken; ADDI proves acc was zero.
        clear_rom();
        rom[0]    = ins(OP_LDI, 8'hFF);
        rom[1]    = ins(OP_ST, 8'h10);
        rom[2]    = ins(OP_LDI, 8'h01);
        rom[3]    = ins(OP_ADD, 8'h10);
        rom[4]    = ins(OP_JC, 8'h20);
        rom[8'h20] = ins(OP_JZ, 8'h30);
        rom[8'h30] = ins(OP_ADDI, 8'h11);
        rom[8'h31] = ins(OP_ST, 8'hFC);
        expect_wr(0, 8'h11);
        do_reset();
        run_cycles(10);
        check_eq("t2_jc_taken_pc", rom_addr, 8'h20);
        run_cycles(20);
        check_eq("t2_final_pc", rom_addr, 8'h33);
        check_eq("t2_sb_drained", sb_q.size(), 0);

        // 2 - 3 -> 0xFF with borrow, Z=0: JZ falls through, JC taken.
        clear_rom();
        rom[0]    = ins(OP_LDI, 8'h03);
        rom[1]    = ins(OP_ST, 8'h10);
        rom[2]    = ins(OP_LDI, 8'h02);
        rom[3]    = ins(OP_SUB, 8'h10);
        rom[4]    = ins(OP_ST, 8'hFC);
        rom[5]    = ins(OP_JZ, 8'h20);
        rom[6]    = ins(OP_JC, 8'h30);
        rom[8'h30] = ins(OP_LDI, 8'h5A);
        rom[8'h31] = ins(OP_ST, 8'hFD);
        expect_wr(0, 8'hFF);
        expect_wr(1, 8'h5A);
        do_reset();
        run_cycles(12);
        check_eq("t3_jz_not_taken_pc", rom_addr, 8'h06);
        run_cycles(30);
        check_eq("t3_final_pc", rom_addr, 8'h33);
        check_eq("t3_sb_drained", sb_q.size(), 0);

        // Logic ops, port read-back, ST then LD of the same RAM address.
        clear_rom();
        rom[0]  = ins(OP_LDI, 8'h3C);
        rom[1]  = ins(OP_ST, 8'h30);
        rom[2]  = ins(OP_LDI, 8'h0F);
        rom[3]  = ins(OP_AND, 8'h30);
        rom[4]  = ins(OP_ST, 8'hFC);
        rom[5]  = ins(OP_OR, 8'h30);
        rom[6]  = ins(OP_ADDI, 8'h01);
        rom[7]  = ins(OP_ST, 8'hFD);
        rom[8]  = ins(OP_XOR, 8'h30);
        rom[9]  = ins(OP_ST, 8'hFE);
        rom[10] = ins(OP_LD, 8'h30);
        rom[11] = ins(OP_ST, 8'hFF);
        rom[12] = ins(OP_LD, 8'hFD);
        rom[13] = ins(OP_ST, 8'h40);
        rom[14] = ins(OP_LD, 8'h40);
        rom[15] = ins(OP_ADDI, 8'h02);
        rom[16] = ins(OP_ST, 8'hFC);
        expect_wr(0, 8'h0C);
        expect_wr(1, 8'h3D);
        expect_wr(2, 8'h01);
        expect_wr(3, 8'h3C);
        expect_wr(0, 8'h3F);
        do_reset();
        run_cycles(50);
        check_eq("t4_final_pc", rom_addr, 8'h12);
        check_eq("t4_sb_drained", sb_q.size(), 0);

        // PC wraps from 0xFF to 0x00; C set by 0xFF+1 steers the second pass.
        clear_rom();
        rom[0]    = ins(OP_JC, 8'h10);
        rom[1]    = ins(OP_LDI, 8'hFF);
        rom[2]    = ins(OP_JMP, 8'hFF);
        rom[8'hFF] = ins(OP_ADDI, 8'h01);
        rom[8'h10] = ins(OP_ADDI, 8'h05);
        rom[8'h11] = ins(OP_ST, 8'hFC);
        expect_wr(0, 8'h05);
        do_reset();
        run_cycles(7);
        check_eq("t5_pc_wrap", rom_addr, 8'h00);
        run_cycles(20);
        check_eq("t5_final_pc", rom_addr, 8'h13);
        check_eq("t5_sb_drained", sb_q.size(), 0);

        // Reset during EXEC of ST 0xFD suppresses the port write.
        clear_rom();
        rom[0] = ins(OP_LDI, 8'h77);
        rom[1] = ins(OP_ST, 8'hFD);
        do_reset();
        run_cycles(3);
        rst = 1'b1;
        run_cycles(1);
        check_eq("t6_port1_aborted", port_out[15:8], 8'h00);
        check_eq("t6_pc_after_rst", rom_addr, 8'h00);
        expect_wr(1, 8'h77);
        rst = 1'b0;
        run_cycles(10);
        check_eq("t6_sb_drained", sb_q.size(), 0);

`ifdef MCU_IRQ_EN
        // Interrupt on JMP 0x40: handler bumps port0, RETI restores Z and IE.
        clear_rom();
        rom[0]    = ins(OP_LDI, 8'h00);
        rom[1]    = ins(OP_SETIE, 8'h01);
        rom[2]    = ins(OP_JMP, 8'h40);
        rom[8'hF0] = ins(OP_LD, 8'hFC);
        rom[8'hF1] = ins(OP_ADDI, 8'h01);
        rom[8'hF2] = ins(OP_ST, 8'hFC);
        rom[8'hF3] = ins(OP_RETI, 8'h00);
        rom[8'h40] = ins(OP_JZ, 8'h50);
        rom[8'h50] = ins(OP_LDI, 8'h44);
        rom[8'h51] = ins(OP_ST, 8'hFD);
        expect_wr(0, 8'h01);
        expect_wr(1, 8'h44);
        expect_wr(0, 8'h02);
        do_reset();
        ack_count = 0;
        run_cycles(4);
        irq = 1'b1;
        run_cycles(2);
        check_eq("t7_irq_ack_pulse", irq_ack, 1);
        irq = 1'b0;
        run_cycles(1);
        check_eq("t7_irq_vec_pc", rom_addr, 8'hF0);
        check_eq("t7_irq_ack_low", irq_ack, 0);
        run_cycles(8);
        check_eq("t7_reti_pc", rom_addr, 8'h40);
        run_cycles(8);
        check_eq("t7_z_restored_pc", rom_addr, 8'h53);
        irq = 1'b1;
        got_ack = 1'b0;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            run_cycles(1);
            if (irq_ack) got_ack = 1'b1;
        end
        check_eq("t7_ie_reenabled_ack", got_ack, 1);
        irq = 1'b0;
        run_cycles(20);
        check_eq("t7_halt_resume_pc", rom_addr, 8'h54);
        check_eq("t7_ack_count", ack_count, 2);
        check_eq("t7_sb_drained", sb_q.size(), 0);
`else
        // Without interrupt support irq is ignored and SETIE/RETI are NOPs.
        clear_rom();
        rom[0]    = ins(OP_LDI, 8'h09);
        rom[1]    = ins(OP_ST, 8'hFE);
        rom[2]    = ins(OP_SETIE, 8'h01);
        rom[3]    = ins(OP_RETI, 8'h00);
        rom[4]    = ins(OP_JMP, 8'h10);
        rom[8'h10] = ins(OP_ST, 8'hFF);
        expect_wr(2, 8'h09);
        expect_wr(3, 8'h09);
        do_reset();
        ack_count = 0;
        irq = 1'b1;
        run_cycles(40);
        check_eq("t7_no_irq_ack", ack_count, 0);
        check_eq("t7_final_pc", rom_addr, 8'h12);
        check_eq("t7_sb_drained", sb_q.size(), 0);
        irq = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
